// File: rtl/rx_frame_burster.sv
// Collects FRAME_LEN received words (or a timed-out partial frame) into a local buffer
// and replays them as a valid/ready burst; words arriving mid-burst are dropped and flagged.
module rx_frame_burster #(
  parameter int DATA_W      = 8,
  parameter int FRAME_LEN   = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_W1 = TO_W + 1;
  localparam int AW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
  localparam logic [TO_W1-1:0] TO_LIM   = TO_W1'(TIMEOUT_CYC);
  localparam logic             TO_EN    = (TIMEOUT_CYC > 0);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [TO_W1-1:0]  idle_inc;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic              in_burst;
  logic              at_last;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign in_burst = (state_q == S_BURST);
  assign at_last  = in_burst && (rd_ptr_q == (len_q - CNT_W'(1)));
  assign idle_inc = {1'b0, idle_cnt_q} + TO_W1'(1);

  // Next-state, counter and pointer logic
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    idle_cnt_d = idle_cnt_q;
    ovf_d      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_FILL: begin
        if (rx_dv) begin
          // an arriving word always beats a timeout firing on the same cycle
          wr_en      = 1'b1;
          wr_cnt_d   = wr_cnt_q + CNT_W'(1);
          idle_cnt_d = {TO_W{1'b0}};
          if (wr_cnt_d == FULL_CNT) begin
            state_d = S_BURST;
            len_d   = FULL_CNT;
          end else begin
            state_d = S_FILL;
          end
        end else if (TO_EN && (wr_cnt_q != {CNT_W{1'b0}})) begin
          if (idle_inc == TO_LIM) begin
            state_d    = S_BURST;
            len_d      = wr_cnt_q;
            idle_cnt_d = {TO_W{1'b0}};
          end else begin
            idle_cnt_d = idle_inc[TO_W-1:0];
          end
        end else begin
          idle_cnt_d = {TO_W{1'b0}};
        end
      end
      S_BURST: begin
        ovf_d = rx_dv;
        if (out_ready) begin
          if (at_last) begin
            state_d    = S_FILL;
            rd_ptr_d   = {CNT_W{1'b0}};
            wr_cnt_d   = {CNT_W{1'b0}};
            idle_cnt_d = {TO_W{1'b0}};
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d    = S_FILL;
        wr_cnt_d   = {CNT_W{1'b0}};
        rd_ptr_d   = {CNT_W{1'b0}};
        idle_cnt_d = {TO_W{1'b0}};
      end
    endcase
  end

  // State, counter and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      wr_cnt_q   <= {CNT_W{1'b0}};
      rd_ptr_q   <= {CNT_W{1'b0}};
      len_q      <= {CNT_W{1'b0}};
      idle_cnt_q <= {TO_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      idle_cnt_q <= idle_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Frame buffer; contents are never visible outside a burst so it needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q[AW-1:0]] <= rx_byte;
    end
  end

  // Output decode from registered state and buffer only
  always_comb begin
    out_valid = in_burst;
    busy      = in_burst;
    out_last  = at_last;
    overflow  = ovf_q;
    if (in_burst) begin
      out_data = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      out_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_rx_frame_burster.sv
// Bench for rx_frame_burster: directed scenarios plus a randomized run against a
// queue-style frame model, on default, timeout=5 and 12-bit/depth-1 instances.
module tb_rx_frame_burster;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx_dv, out_ready;
  logic [7:0]  rx_byte;
  logic        rx_dv2, out_ready2;
  logic [11:0] rx_byte2;
  logic [1:0]  o_valid, o_last, o_busy, o_ovf;
  logic [7:0]  o_data [2];
  logic        v2, l2, b2, ov2;
  logic [11:0] d2;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0: no timeout, index 1: timeout 5
  logic [7:0] m_fill  [2][4];
  logic [7:0] m_burst [2][4];
  int         m_fn [2], m_bn [2], m_bi [2], m_idle [2], m_to [2];
  logic       m_ovf [2];

  rx_frame_burster u0 (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]),
    .out_last(o_last[0]), .busy(o_busy[0]), .overflow(o_ovf[0])
  );

  rx_frame_burster #(.TIMEOUT_CYC(5)) u1 (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]),
    .out_last(o_last[1]), .busy(o_busy[1]), .overflow(o_ovf[1])
  );

  rx_frame_burster #(.DATA_W(12), .FRAME_LEN(1)) u2 (
    .clk(clk), .rst(rst), .rx_dv(rx_dv2), .rx_byte(rx_byte2),
    .out_valid(v2), .out_ready(out_ready2), .out_data(d2),
    .out_last(l2), .busy(b2), .overflow(ov2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_dv = 1'b0; rx_dv2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [4]);
    for (int i = 0; i < 4; i++) begin
      rx_dv = 1'b1; rx_byte = f[i];
      tick();
    end
    rx_dv = 1'b0;
  endtask

  task automatic test_reset();
    rx_dv = 1'b1; rx_byte = 8'h5A;
    tick();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({o_valid[m], o_last[m], o_busy[m], o_ovf[m]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctl%0d: got v/l/b/o=%b%b%b%b expected 0000", m, o_valid[m], o_last[m], o_busy[m], o_ovf[m]);
      end
      checks++;
      if (o_data[m] !== 8'h00) begin
        errors++;
        $display("FAIL reset_data%0d: got %h expected 00", m, o_data[m]);
      end
    end
    checks++;
    if ({v2, l2, b2, ov2, d2} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_w12: got v/l/b/o=%b%b%b%b data=%h expected all 0", v2, l2, b2, ov2, d2);
    end
  endtask

  task automatic test_basic();
    logic [7:0] f [4];
    f[0] = 8'h11; f[1] = 8'h22; f[2] = 8'h33; f[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_dv = 1'b1; rx_byte = f[i];
      checks++;
      if (o_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_early: cycle %0d valid=%b expected 0", i, o_valid[0]);
      end
      tick();
    end
    rx_dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_valid[0], o_last[0]} !== {1'b1, (k == 3)} || o_data[0] !== f[k]) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", k, o_valid[0], o_last[0], o_data[0], (k == 3), f[k]);
      end
      tick();
    end
    checks++;
    if (o_valid[0] !== 1'b0 || o_data[0] !== 8'h00) begin
      errors++;
      $display("FAIL basic_end: got v=%b d=%h expected v=0 d=00", o_valid[0], o_data[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] f [4];
    logic [6:0] pat;
    logic       ev, el;
    logic [7:0] ed;
    int idx, xf;
    pat = 7'b1001101;
    for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
    do_reset();
    send_frame(f);
    idx = 0; xf = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = (c < 7) ? pat[6-c] : 1'b1;
      ev = (idx < 4);
      ed = ev ? f[idx] : 8'h00;
      el = (idx == 3);
      checks++;
      if ({o_valid[0], o_last[0]} !== {ev, el} || o_data[0] !== ed) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b l=%b d=%h expected v=%b l=%b d=%h", c, o_valid[0], o_last[0], o_data[0], ev, el, ed);
      end
      if (o_valid[0] && out_ready) xf++;
      if (ev && out_ready) idx++;
      tick();
    end
    checks++;
    if (xf !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d transfers expected 4", xf);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp3 [3];
    exp3[0] = 8'hA5; exp3[1] = 8'h5A; exp3[2] = 8'h3C;
    // plain flush: A5,5A then idle
    do_reset();
    rx_dv = 1'b1; rx_byte = 8'hA5; tick();
    rx_byte = 8'h5A; tick();
    rx_dv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (o_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL to_early: t+%0d valid=%b expected 0", k, o_valid[1]);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_valid[1], o_last[1]} !== {1'b1, (k == 1)} || o_data[1] !== exp3[k]) begin
        errors++;
        $display("FAIL to_word%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", k, o_valid[1], o_last[1], o_data[1], (k == 1), exp3[k]);
      end
      tick();
    end
    checks++;
    if (o_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL to_end: valid=%b expected 0", o_valid[1]);
    end
    // word on the cycle the timeout would fire: accepted, timer restarts
    do_reset();
    rx_dv = 1'b1; rx_byte = 8'hA5; tick();
    rx_byte = 8'h5A; tick();
    rx_dv = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rx_dv = 1'b1; rx_byte = 8'h3C; tick();
    rx_dv = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      checks++;
      if (o_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL to_race_early: t+%0d valid=%b expected 0", k, o_valid[1]);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_valid[1], o_last[1]} !== {1'b1, (k == 2)} || o_data[1] !== exp3[k]) begin
        errors++;
        $display("FAIL to_race_word%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", k, o_valid[1], o_last[1], o_data[1], (k == 2), exp3[k]);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] f [4];
    logic [7:0] g [4];
    logic       ev, eo;
    logic [7:0] ed;
    for (int i = 0; i < 4; i++) begin
      f[i] = 8'($urandom);
      g[i] = 8'($urandom);
    end
    do_reset();
    send_frame(f);
    for (int c = 1; c <= 6; c++) begin
      rx_dv   = (c == 2 || c == 4);
      rx_byte = (c == 2) ? 8'h77 : 8'h99;
      ev = (c <= 4);
      ed = ev ? f[c-1] : 8'h00;
      eo = (c == 3 || c == 5);
      checks++;
      if (o_valid[0] !== ev || o_data[0] !== ed || o_ovf[0] !== eo) begin
        errors++;
        $display("FAIL ovf_cycle%0d: got v=%b d=%h o=%b expected v=%b d=%h o=%b", c, o_valid[0], o_data[0], o_ovf[0], ev, ed, eo);
      end
      tick();
    end
    rx_dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_dv = 1'b1; rx_byte = g[i];
      checks++;
      if (o_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL ovf_leak: valid=%b while sending word %0d expected 0", o_valid[0], i);
      end
      tick();
    end
    rx_dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_valid[0], o_last[0]} !== {1'b1, (k == 3)} || o_data[0] !== g[k]) begin
        errors++;
        $display("FAIL ovf_next%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", k, o_valid[0], o_last[0], o_data[0], (k == 3), g[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] f [4];
    logic [7:0] g [4];
    for (int i = 0; i < 4; i++) begin
      f[i] = 8'($urandom);
      g[i] = 8'($urandom);
    end
    do_reset();
    send_frame(f);
    tick();
    tick();
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++;
    if ({o_valid[0], o_last[0], o_busy[0], o_ovf[0]} !== 4'b0000 || o_data[0] !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got v/l/b/o=%b%b%b%b d=%h expected all 0", o_valid[0], o_last[0], o_busy[0], o_ovf[0], o_data[0]);
    end
    send_frame(g);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({o_valid[0], o_last[0]} !== {1'b1, (k == 3)} || o_data[0] !== g[k]) begin
        errors++;
        $display("FAIL rst_fresh%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", k, o_valid[0], o_last[0], o_data[0], (k == 3), g[k]);
      end
      tick();
    end
  endtask

  task automatic test_width();
    logic [11:0] w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 12'hABC : 12'($urandom);
      rx_dv2 = 1'b1; rx_byte2 = w;
      tick();
      rx_dv2 = 1'b0; out_ready2 = (i % 2 == 0);
      checks++;
      if ({v2, l2, b2} !== 3'b111 || d2 !== w) begin
        errors++;
        $display("FAIL w12_word%0d: got v/l/b=%b%b%b d=%h expected 111 d=%h", i, v2, l2, b2, d2, w);
      end
      if (!out_ready2) begin
        tick();
        out_ready2 = 1'b1;
        checks++;
        if ({v2, l2} !== 2'b11 || d2 !== w) begin
          errors++;
          $display("FAIL w12_hold%0d: got v/l=%b%b d=%h expected 11 d=%h", i, v2, l2, d2, w);
        end
      end
      tick();
      checks++;
      if (v2 !== 1'b0 || d2 !== 12'h000) begin
        errors++;
        $display("FAIL w12_end%0d: got v=%b d=%h expected v=0 d=000", i, v2, d2);
      end
    end
  endtask

  task automatic test_random(input int ncyc);
    logic       ev, el, dv, rd;
    logic [7:0] ed, by;
    do_reset();
    m_to[0] = 0;
    m_to[1] = 5;
    for (int m = 0; m < 2; m++) begin
      m_fn[m] = 0; m_bn[m] = 0; m_bi[m] = 0; m_idle[m] = 0; m_ovf[m] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int m = 0; m < 2; m++) begin
        ev = (m_bn[m] > 0);
        ed = ev ? m_burst[m][m_bi[m]] : 8'h00;
        el = ev && (m_bi[m] == m_bn[m] - 1);
        checks++;
        if ({o_valid[m], o_busy[m], o_last[m]} !== {ev, ev, el} || o_data[m] !== ed || o_ovf[m] !== m_ovf[m]) begin
          errors++;
          $display("FAIL rand%0d cyc %0d: got v/b/l=%b%b%b d=%h o=%b expected %b%b%b d=%h o=%b",
                   m, c, o_valid[m], o_busy[m], o_last[m], o_data[m], o_ovf[m], ev, ev, el, ed, m_ovf[m]);
        end
      end
      dv = ($urandom_range(0, 99) < 35);
      by = 8'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      rx_dv = dv; rx_byte = by; out_ready = rd;
      for (int m = 0; m < 2; m++) begin
        if (m_bn[m] > 0) begin
          m_ovf[m] = dv;
          if (rd) begin
            m_bi[m]++;
            if (m_bi[m] == m_bn[m]) begin
              m_bn[m] = 0;
              m_bi[m] = 0;
            end
          end
        end else begin
          m_ovf[m] = 1'b0;
          if (dv) begin
            m_fill[m][m_fn[m]] = by;
            m_fn[m]++;
            m_idle[m] = 0;
            if (m_fn[m] == 4) begin
              for (int i = 0; i < 4; i++) m_burst[m][i] = m_fill[m][i];
              m_bn[m] = 4;
              m_fn[m] = 0;
            end
          end else if (m_to[m] > 0 && m_fn[m] > 0) begin
            m_idle[m]++;
            if (m_idle[m] == m_to[m]) begin
              for (int i = 0; i < 4; i++) m_burst[m][i] = m_fill[m][i];
              m_bn[m] = m_fn[m];
              m_fn[m] = 0;
              m_idle[m] = 0;
            end
          end
        end
      end
      tick();
    end
    rx_dv = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; out_ready = 1'b1;
    rx_dv2 = 1'b0; rx_byte2 = 12'h000; out_ready2 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_overflow();
    test_reset_mid_burst();
    test_width();
    test_random(800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
